// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if -- bundles the instruction/memory inputs and every
// datapath control line between the multicycle control FSM and the datapath.
// The datapath side uses the master modport, the controller the slave modport.
interface multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM of the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback from the 6-bit opcode and
// drives all datapath enables and selects as registered Moore outputs.
// Optional feature macro MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall until
// mem_ready is high; without it mem_ready is ignored.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_ctrl_if.slave bus
);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 0,
        S_FETCH    = 1,
        S_DECODE   = 2,
        S_MEMADR   = 3,
        S_MEMRD    = 4,
        S_MEMWB    = 5,
        S_MEMWR    = 6,
        S_RTYPE_EX = 7,
        S_RTYPE_WB = 8,
        S_BEQ_EX   = 9,
        S_J_EX     = 10,
        S_ADDI_EX  = 11,
        S_ADDI_WB  = 12
    } stateT;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrlT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    stateT state_q;
    stateT state_d;
    ctrlT  ctrl_q;
    logic  fetchStall;
    logic  opLegal;

    // Control word belonging to each state; anything not named stays 0,
    // which also covers IDLE and the unused encodings.
    function automatic ctrlT decodeState(stateT s);
        ctrlT c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memRead = 1'b1;
                c.irWrite = 1'b1;
                c.aluSrcB = 2'b01;
                c.pcWrite = 1'b1;
            end
            S_DECODE: begin
                c.aluSrcB = 2'b11;
            end
            S_MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                c.memRead = 1'b1;
                c.iOrD    = 1'b1;
            end
            S_MEMWB: begin
                c.regWrite = 1'b1;
                c.memToReg = 1'b1;
            end
            S_MEMWR: begin
                c.memWrite = 1'b1;
                c.iOrD     = 1'b1;
            end
            S_RTYPE_EX: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = 2'b10;
            end
            S_RTYPE_WB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b1;
            end
            S_BEQ_EX: begin
                c.aluSrcA     = 1'b1;
                c.aluOp       = 2'b01;
                c.pcWriteCond = 1'b1;
                c.pcSource    = 2'b01;
            end
            S_J_EX: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'b10;
            end
            S_ADDI_EX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            S_ADDI_WB: begin
                c.regWrite = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Flags opcodes the decoder knows how to dispatch.
    always_comb begin
        opLegal = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opLegal = 1'b1;
            default: opLegal = 1'b0;
        endcase
    end

    // Next-state selection; memory states may stall on mem_ready when enabled.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_J:         state_d = S_J_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ_EX:   state_d = S_FETCH;
            S_J_EX:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
`ifdef MEM_WAIT_EN
        if (((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
            && !bus.mem_ready) begin
            state_d = state_q;
        end
`endif
    end

    // State register with the control word of the upcoming state registered
    // alongside it, so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decodeState(state_d);
        end
    end

`ifdef MEM_WAIT_EN
    // A held FETCH must load PC and IR only once, in the cycle memory is ready.
    assign fetchStall = (state_q == S_FETCH) && !bus.mem_ready;
`else
    logic unusedMemReady;
    assign unusedMemReady = bus.mem_ready;
    assign fetchStall     = 1'b0;
`endif

    assign bus.pc_write      = ctrl_q.pcWrite & ~fetchStall;
    assign bus.ir_write      = ctrl_q.irWrite & ~fetchStall;
    assign bus.pc_write_cond = ctrl_q.pcWriteCond;
    assign bus.i_or_d        = ctrl_q.iOrD;
    assign bus.mem_read      = ctrl_q.memRead;
    assign bus.mem_write     = ctrl_q.memWrite;
    assign bus.mem_to_reg    = ctrl_q.memToReg;
    assign bus.reg_dst       = ctrl_q.regDst;
    assign bus.reg_write     = ctrl_q.regWrite;
    assign bus.alu_src_a     = ctrl_q.aluSrcA;
    assign bus.alu_src_b     = ctrl_q.aluSrcB;
    assign bus.alu_op        = ctrl_q.aluOp;
    assign bus.pc_source     = ctrl_q.pcSource;
    assign bus.illegal_op    = (state_q == S_DECODE) && !opLegal;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- directed-vector bench for the multicycle control FSM.
// Walks each instruction class through its state sequence and compares the
// state and the packed control word every cycle against hand-written values.
// The mem_ready stall vectors are included when MEM_WAIT_EN is defined.
module tb_multicycle_ctrl;

    // Control word layout, MSB first:
    // pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
    // alu_op[1:0], pc_source[1:0], illegal_op
    localparam logic [16:0] EXP_IDLE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXP_FETCH   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXP_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXP_ILLEGAL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
    localparam logic [16:0] EXP_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXP_MEMRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXP_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXP_MEMWR   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXP_RTEX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [16:0] EXP_RTWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXP_BEQ     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [16:0] EXP_J       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [16:0] EXP_ADDIEX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXP_ADDIWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
`ifdef MEM_WAIT_EN
    localparam logic [16:0] EXP_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
`endif

    logic        clk;
    logic        reset;
    logic [16:0] ctlObs;
    int          vectorCount;
    int          missCount;

    multicycle_ctrl_if #(.STATE_W(4)) bus ();

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the observed control outputs into the same layout as the constants.
    assign ctlObs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source, bus.illegal_op};

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents a new opcode as if the IR had just been loaded.
    task automatic applyStimulus(input logic [5:0] op);
        bus.opcode = op;
    endtask

    // Moves to just after the next rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Compares the current state and control word.
    task automatic checkCycle(input string tag, input int expState, input logic [16:0] expCtl);
        checkOutput({tag, "_state"}, 32'(bus.state), 32'(expState));
        checkOutput({tag, "_ctl"}, 32'(ctlObs), 32'(expCtl));
    endtask

    // Checks the current cycle and then advances one clock.
    task automatic expectCycle(input string tag, input int expState, input logic [16:0] expCtl);
        checkCycle(tag, expState, expCtl);
        stepClock();
    endtask

    // Directed sequence: reset, every instruction class, stall, mid-instruction reset.
    initial begin
        vectorCount   = 0;
        missCount     = 0;
        reset         = 1'b1;
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expectCycle("rst_idle", 0, EXP_IDLE);

        applyStimulus(6'b000000);
        expectCycle("rt_fetch", 1, EXP_FETCH);
        expectCycle("rt_decode", 2, EXP_DECODE);
        expectCycle("rt_ex", 7, EXP_RTEX);
        expectCycle("rt_wb", 8, EXP_RTWB);

        applyStimulus(6'b100011);
        expectCycle("lw_fetch", 1, EXP_FETCH);
        expectCycle("lw_decode", 2, EXP_DECODE);
        expectCycle("lw_memadr", 3, EXP_MEMADR);
        expectCycle("lw_memrd", 4, EXP_MEMRD);
        expectCycle("lw_memwb", 5, EXP_MEMWB);

        applyStimulus(6'b101011);
        expectCycle("sw_fetch", 1, EXP_FETCH);
        expectCycle("sw_decode", 2, EXP_DECODE);
        expectCycle("sw_memadr", 3, EXP_MEMADR);
        expectCycle("sw_memwr", 6, EXP_MEMWR);

        applyStimulus(6'b000100);
        expectCycle("beq_fetch", 1, EXP_FETCH);
        expectCycle("beq_decode", 2, EXP_DECODE);
        expectCycle("beq_ex", 9, EXP_BEQ);

        applyStimulus(6'b000010);
        expectCycle("j_fetch", 1, EXP_FETCH);
        expectCycle("j_decode", 2, EXP_DECODE);
        expectCycle("j_ex", 10, EXP_J);

        applyStimulus(6'b001000);
        expectCycle("addi_fetch", 1, EXP_FETCH);
        expectCycle("addi_decode", 2, EXP_DECODE);
        expectCycle("addi_ex", 11, EXP_ADDIEX);
        expectCycle("addi_wb", 12, EXP_ADDIWB);

        applyStimulus(6'b111111);
        expectCycle("ill_fetch", 1, EXP_FETCH);
        expectCycle("ill_decode", 2, EXP_ILLEGAL);

`ifdef MEM_WAIT_EN
        applyStimulus(6'b000010);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expectCycle("wait_hold", 1, EXP_FETCH_WAIT);
        end
        bus.mem_ready = 1'b1;
        expectCycle("wait_go", 1, EXP_FETCH);
        expectCycle("wait_decode", 2, EXP_DECODE);
        expectCycle("wait_j", 10, EXP_J);
`endif

        applyStimulus(6'b100011);
        expectCycle("abort_fetch", 1, EXP_FETCH);
        expectCycle("abort_decode", 2, EXP_DECODE);
        expectCycle("abort_memadr", 3, EXP_MEMADR);
        checkCycle("abort_memrd", 4, EXP_MEMRD);
        reset = 1'b1;
        stepClock();
        checkCycle("abort_reset", 0, EXP_IDLE);
        checkOutput("abort_no_regwrite", 32'(bus.reg_write), 32'd0);
        reset = 1'b0;
        stepClock();
        checkCycle("abort_refetch", 1, EXP_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
